fifo_dual: RTL and testbench

Two-wide in-order FIFO for superscalar front-end and issue queues. Accepts up to two entries per cycle and delivers up to two per cycle. Uses all 2^WIDTH slots via an explicit occupancy counter, and exposes that count to producers. Sits between fetch and decode, and between decode and issue, where dual-slot handshakes are needed.

---
 rtl/fifo_dual.sv | 54 +++++
 tb/tb_fifo_dual.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fifo_dual.sv
// fifo_dual: two-wide in-order FIFO using all 2^WIDTH slots through an occupancy counter
module fifo_dual #(
  parameter type DATA_TYPE = logic,
  parameter int  WIDTH     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [1:0]   wvalid,
  input  DATA_TYPE     wdata0,
  input  DATA_TYPE     wdata1,
  output logic         wready,
  output logic         wready_two,
  input  logic [1:0]   rready,
  output logic         rvalid,
  output logic         rvalid_two,
  output DATA_TYPE     rdata0,
  output DATA_TYPE     rdata1,
  output logic [WIDTH:0] count
);
  localparam int DEPTH = 1 << WIDTH;
  localparam logic [WIDTH:0] ALMOST = (WIDTH+1)'(DEPTH - 1);
  DATA_TYPE mem [DEPTH];
  logic [WIDTH-1:0] head, tail;
  logic push0, push1, pop0, pop1;
  // flags come from registered count only, so same-cycle pops never free space
  assign wready     = count <= ALMOST;
  assign wready_two = count < ALMOST;
  assign rvalid     = count != '0;
  assign rvalid_two = count > (WIDTH+1)'(1);
  assign push0 = wvalid[0] && wready;
  assign push1 = wvalid[0] && wvalid[1] && wready_two;
  assign pop0  = rready[0] && rvalid;
  assign pop1  = rready[0] && rready[1] && rvalid_two;
  assign rdata0 = rvalid ? mem[head] : '0;
  assign rdata1 = rvalid_two ? mem[head + WIDTH'(1)] : '0;
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + WIDTH'(pop0) + WIDTH'(pop1);
      tail  <= tail + WIDTH'(push0) + WIDTH'(push1);
      count <= count + (WIDTH+1)'(push0) + (WIDTH+1)'(push1) - (WIDTH+1)'(pop0) - (WIDTH+1)'(pop1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      if (push0) mem[tail] <= wdata0;
      if (push1) mem[tail + WIDTH'(1)] <= wdata1;
    end
  end
endmodule

// File: tb/tb_fifo_dual.sv
// tb_fifo_dual: directed self-checking bench for fifo_dual with 8-bit entries, depth 4
module tb_fifo_dual;
  logic       clk = 0;
  logic       rst = 0;
  logic       flush = 0;
  logic [1:0] wvalid = '0;
  logic [7:0] wdata0 = '0;
  logic [7:0] wdata1 = '0;
  logic [1:0] rready = '0;
  logic       wready, wready_two, rvalid, rvalid_two;
  logic [7:0] rdata0, rdata1;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;

  fifo_dual #(.DATA_TYPE(logic [7:0]), .WIDTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wvalid(wvalid), .wdata0(wdata0), .wdata1(wdata1),
    .wready(wready), .wready_two(wready_two), .rready(rready), .rvalid(rvalid),
    .rvalid_two(rvalid_two), .rdata0(rdata0), .rdata1(rdata1), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] wv, input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] rr);
    wvalid = wv;
    wdata0 = d0;
    wdata1 = d1;
    rready = rr;
    @(posedge clk);
    #1;
    wvalid = '0;
    rready = '0;
  endtask

  initial begin
    cyc(2'b00, 8'h00, 8'h00, 2'b00);
    check("rst_count", 32'(count), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rvalid_two", 32'(rvalid_two), 0);
    check("rst_wready", 32'(wready), 1);
    check("rst_wready_two", 32'(wready_two), 1);
    check("rst_rdata0", 32'(rdata0), 0);
    rst = 1;
    cyc(2'b11, 8'hA1, 8'hB2, 2'b00);
    cyc(2'b01, 8'hC3, 8'h00, 2'b00);
    check("abc_count", 32'(count), 3);
    check("abc_rdata0", 32'(rdata0), 32'hA1);
    check("abc_rdata1", 32'(rdata1), 32'hB2);
    check("abc_rvalid_two", 32'(rvalid_two), 1);
    cyc(2'b00, 8'h00, 8'h00, 2'b11);
    check("pop2_count", 32'(count), 1);
    check("pop2_rdata0", 32'(rdata0), 32'hC3);
    check("pop2_rvalid", 32'(rvalid), 1);
    check("pop2_rvalid_two", 32'(rvalid_two), 0);
    check("pop2_rdata1", 32'(rdata1), 0);
    cyc(2'b00, 8'h00, 8'h00, 2'b01);
    check("empty_count", 32'(count), 0);
    // head and tail now both sit at slot 3: dual push wraps into slot 0
    cyc(2'b11, 8'h58, 8'h59, 2'b00);
    check("wrap_count", 32'(count), 2);
    check("wrap_rdata0", 32'(rdata0), 32'h58);
    check("wrap_rdata1", 32'(rdata1), 32'h59);
    cyc(2'b00, 8'h00, 8'h00, 2'b11);
    check("wrap_pop_count", 32'(count), 0);
    check("wrap_pop_rvalid", 32'(rvalid), 0);
    check("wrap_pop_rdata0", 32'(rdata0), 0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 8'(8'h10 + i), 8'h00, 2'b00);
    check("c3_count", 32'(count), 3);
    check("c3_wready", 32'(wready), 1);
    check("c3_wready_two", 32'(wready_two), 0);
    cyc(2'b01, 8'h13, 8'h00, 2'b00);
    check("full_count", 32'(count), 4);
    check("full_wready", 32'(wready), 0);
    cyc(2'b11, 8'hEE, 8'hEF, 2'b00);
    check("full_refuse_count", 32'(count), 4);
    check("full_refuse_rdata0", 32'(rdata0), 32'h10);
    check("full_refuse_rdata1", 32'(rdata1), 32'h11);
    cyc(2'b01, 8'hEE, 8'h00, 2'b01);
    check("full_pop_count", 32'(count), 3);
    check("full_pop_rdata0", 32'(rdata0), 32'h11);
    check("full_pop_rdata1", 32'(rdata1), 32'h12);
    cyc(2'b00, 8'h00, 8'h00, 2'b01);
    cyc(2'b01, 8'h14, 8'h00, 2'b00);
    check("c3b_count", 32'(count), 3);
    cyc(2'b11, 8'h15, 8'h16, 2'b00);
    check("one_of_two_count", 32'(count), 4);
    cyc(2'b00, 8'h00, 8'h00, 2'b11);
    check("one_of_two_rdata0", 32'(rdata0), 32'h14);
    check("one_of_two_rdata1", 32'(rdata1), 32'h15);
    cyc(2'b01, 8'h17, 8'h00, 2'b00);
    cyc(2'b11, 8'h18, 8'h19, 2'b01);
    check("push_pop_count", 32'(count), 3);
    check("push_pop_rdata0", 32'(rdata0), 32'h15);
    check("push_pop_rdata1", 32'(rdata1), 32'h17);
    flush = 1;
    cyc(2'b11, 8'h20, 8'h21, 2'b00);
    flush = 0;
    check("flush_count", 32'(count), 0);
    check("flush_rvalid", 32'(rvalid), 0);
    check("flush_rdata0", 32'(rdata0), 0);
    cyc(2'b01, 8'h5A, 8'h00, 2'b00);
    check("post_flush_rdata0", 32'(rdata0), 32'h5A);
    check("post_flush_count", 32'(count), 1);
    cyc(2'b11, 8'h30, 8'h31, 2'b00);
    rst = 0;
    cyc(2'b11, 8'h32, 8'h33, 2'b11);
    rst = 1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_rvalid_two", 32'(rvalid_two), 0);
    check("mid_rst_wready", 32'(wready), 1);
    check("mid_rst_wready_two", 32'(wready_two), 1);
    check("mid_rst_rdata1", 32'(rdata1), 0);
    cyc(2'b01, 8'h40, 8'h00, 2'b00);
    cyc(2'b10, 8'h41, 8'h42, 2'b00);
    check("wv10_count", 32'(count), 1);
    cyc(2'b00, 8'h00, 8'h00, 2'b10);
    check("rr10_count", 32'(count), 1);
    check("rr10_rdata0", 32'(rdata0), 32'h40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
